// File: rtl/instr_mem_loader_if.sv
// Host load stream and fetch port of the loadable instruction memory.
// Master side drives loads/fetches; slave side is the memory.
interface instr_mem_loader_if #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16
);
    logic                  load_start;
    logic [7:0]            load_byte;
    logic                  load_valid;
    logic                  load_ready;
    logic                  load_done;
    logic                  fetch;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instr_valid;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] word_count;
    logic                  load_error;

    modport master (
        output load_start, load_byte, load_valid, load_done,
        output fetch, address,
        input  load_ready, instruction, instr_valid,
        input  mode, word_count, load_error
    );

    modport slave (
        input  load_start, load_byte, load_valid, load_done,
        input  fetch, address,
        output load_ready, instruction, instr_valid,
        output mode, word_count, load_error
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory: byte-stream loader plus
// registered fetch port returning DEFAULT_WORD for unloaded addresses.
module instr_mem_loader #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'('hAA)
) (
    input logic clk,
    input logic rst_n,
    instr_mem_loader_if.slave bus
);
    localparam int LANES = (DATA_WIDTH + 7) / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]            state;
    logic [LW-1:0]         lane;
    logic [DATA_WIDTH-1:0] part;
    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] count;
    logic                  err;
    logic [DATA_WIDTH-1:0] instr;
    logic                  ivalid;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic full;
    logic ready;
    logic accept;
    logic last;
    logic in_range;

    always_comb begin
        full     = {1'b0, count} >= DEPTH_W;
        ready    = (state == LOAD) && !full;
        accept   = ready && bus.load_valid
                   && !bus.load_done && !bus.load_start;
        last     = lane == LW'(LANES - 1);
        in_range = bus.address < count;
    end

    // Little-endian lane merge; bits past DATA_WIDTH never exist.
    always_comb begin
        word = part;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if ((i / 8) == int'(lane))
                word[i] = bus.load_byte[i % 8];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && last)
            mem[count[MW-1:0]] <= word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            lane   <= '0;
            part   <= '0;
            count  <= '0;
            err    <= 1'b0;
            instr  <= DEFAULT_WORD;
            ivalid <= 1'b0;
        end else begin
            ivalid <= 1'b0;
            if (state == RUN && bus.fetch) begin
                ivalid <= 1'b1;
                instr  <= in_range ? mem[bus.address[MW-1:0]]
                                   : DEFAULT_WORD;
            end
            if (bus.load_start) begin
                state <= LOAD;
                lane  <= '0;
                part  <= '0;
                count <= '0;
                err   <= 1'b0;
            end else if (state == LOAD) begin
                if (bus.load_done) begin
                    state <= RUN;
                    lane  <= '0;
                    part  <= '0;
                    if (lane != '0)
                        err <= 1'b1;
                    if (bus.load_valid && full)
                        err <= 1'b1;
                end else if (accept) begin
                    if (last) begin
                        lane  <= '0;
                        part  <= '0;
                        count <= count + ADDR_WIDTH'(1);
                    end else begin
                        lane <= lane + LW'(1);
                        part <= word;
                    end
                end else if (bus.load_valid) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign bus.load_ready  = ready;
    assign bus.instruction = instr;
    assign bus.instr_valid = ivalid;
    assign bus.mode        = state;
    assign bus.word_count  = count;
    assign bus.load_error  = err;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader with DEPTH = 4.
// Fetch results are checked through an expected-value queue.
module tb_instr_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.DATA_WIDTH(28), .ADDR_WIDTH(16)) bus ();

    instr_mem_loader #(
        .DATA_WIDTH(28),
        .ADDR_WIDTH(16),
        .DEPTH(4),
        .DEFAULT_WORD(28'h00000AA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [27:0] exp;
    } fvec_t;

    int passed = 0;
    int total  = 0;
    logic [27:0] sb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        logic [27:0] e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("fetch_valid", 32'(bus.instr_valid), 32'd1);
            check("fetch_data", 32'(bus.instruction), 32'(e));
        end else begin
            check("no_valid", 32'(bus.instr_valid), 32'd0);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.load_byte  = b;
        bus.load_valid = 1'b1;
        cyc();
        bus.load_valid = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [27:0] e);
        bus.fetch   = 1'b1;
        bus.address = a;
        sb.push_back(e);
        cyc();
        bus.fetch = 1'b0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.load_done = 1'b1;
        cyc();
        bus.load_done = 1'b0;
    endtask

    initial begin
        fvec_t main_tbl[4];
        logic [7:0] prog[12];
        logic [31:0] w;

        main_tbl[0] = '{16'd0, 28'h2345678};
        main_tbl[1] = '{16'd1, 28'h0000001};
        main_tbl[2] = '{16'd2, 28'hFFFFFFF};
        main_tbl[3] = '{16'd3, 28'h00000AA};
        prog = '{8'h78, 8'h56, 8'h34, 8'hF2,
                 8'h01, 8'h00, 8'h00, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        bus.load_start = 1'b0;
        bus.load_byte  = 8'h00;
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b0;
        bus.fetch      = 1'b0;
        bus.address    = 16'd0;

        // reset state and IDLE behaviour
        cyc();
        cyc();
        rst_n = 1'b1;
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_instr", 32'(bus.instruction), 32'h00000AA);
        check("rst_count", 32'(bus.word_count), 32'd0);
        check("rst_err", 32'(bus.load_error), 32'd0);
        check("rst_ready", 32'(bus.load_ready), 32'd0);
        bus.fetch = 1'b1;
        cyc();
        bus.fetch = 1'b0;
        check("idle_instr", 32'(bus.instruction), 32'h00000AA);
        pulse_done();
        check("idle_done_mode", 32'(bus.mode), 32'd0);

        // main load of three words, table-driven fetches
        pulse_start();
        check("load_mode", 32'(bus.mode), 32'd1);
        check("load_ready", 32'(bus.load_ready), 32'd1);
        for (int i = 0; i < 12; i++) send(prog[i]);
        pulse_done();
        check("main_mode", 32'(bus.mode), 32'd2);
        check("main_count", 32'(bus.word_count), 32'd3);
        check("main_err", 32'(bus.load_error), 32'd0);
        for (int i = 0; i < 4; i++) fetch(main_tbl[i].addr, main_tbl[i].exp);
        cyc();
        check("hold_instr", 32'(bus.instruction), 32'h00000AA);

        // restart from RUN with start and done together
        bus.load_start = 1'b1;
        bus.load_done  = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        bus.load_done  = 1'b0;
        check("restart_mode", 32'(bus.mode), 32'd1);
        check("restart_count", 32'(bus.word_count), 32'd0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        pulse_done();
        check("reload_count", 32'(bus.word_count), 32'd1);
        check("reload_err", 32'(bus.load_error), 32'd0);
        fetch(16'd0, 28'h4332211);
        fetch(16'd1, 28'h00000AA);
        cyc();

        // overflow with valid held high
        pulse_start();
        bus.load_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.load_byte = 8'(8'hA0 + i);
            check("ovf_ready", 32'(bus.load_ready), (i < 16) ? 32'd1 : 32'd0);
            cyc();
            if (i == 15) check("ovf_err_pre", 32'(bus.load_error), 32'd0);
            if (i == 16) check("ovf_err", 32'(bus.load_error), 32'd1);
        end
        bus.load_valid = 1'b0;
        check("ovf_count", 32'(bus.word_count), 32'd4);
        pulse_done();
        check("ovf_mode", 32'(bus.mode), 32'd2);
        check("ovf_err_sticky", 32'(bus.load_error), 32'd1);
        for (int k = 0; k < 4; k++) begin
            w = {8'(8'hA3 + 4 * k), 8'(8'hA2 + 4 * k),
                 8'(8'hA1 + 4 * k), 8'(8'hA0 + 4 * k)};
            fetch(16'(k), w[27:0]);
        end
        cyc();

        // partial word at done
        pulse_start();
        check("partial_err_clr", 32'(bus.load_error), 32'd0);
        for (int i = 1; i <= 6; i++) send(8'(i));
        pulse_done();
        check("partial_count", 32'(bus.word_count), 32'd1);
        check("partial_err", 32'(bus.load_error), 32'd1);
        fetch(16'd1, 28'h00000AA);
        fetch(16'd0, 28'h4030201);
        cyc();

        // reset mid-word, then lanes must realign
        pulse_start();
        send(8'hAB);
        send(8'hCD);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("midrst_mode", 32'(bus.mode), 32'd0);
        check("midrst_count", 32'(bus.word_count), 32'd0);
        pulse_start();
        for (int i = 0; i < 4; i++) send(prog[i]);
        pulse_done();
        check("realign_count", 32'(bus.word_count), 32'd1);
        fetch(16'd0, 28'h2345678);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Parametrised, run-time loadable instruction memory. It is the successor to the fixed case-table program ROM.
- A host streams the program in byte by byte over a valid/ready port. The block assembles bytes into DATA_WIDTH-bit instruction words and writes them at auto-incrementing addresses.
- It then serves registered instruction fetches to the processor's fetch stage.
- Unloaded or out-of-range addresses return a configurable default instruction.

Parameters:
- DATA_WIDTH, 28, instruction word width; number of byte lanes LANES = ceil(DATA_WIDTH/8), derived.
- ADDR_WIDTH, 16, width of the address and word-count ports.
- DEPTH, 256, number of instruction words stored; DEPTH <= 2**ADDR_WIDTH.
- DEFAULT_WORD, 28'h00000AA, word returned for addresses that are unloaded or out of range.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- iLoadStart  in  1  one-cycle pulse: enter LOAD, clear the write pointer and word count.
- iLoadByte  in  8  program byte.
- iLoadValid  in  1  iLoadByte is valid.
- oLoadReady  out  1  block can accept a byte; combinational.
- iLoadDone  in  1  one-cycle pulse: end LOAD, enter RUN.
- iFetch  in  1  fetch request.
- iAddress  in  ADDR_WIDTH  fetch address.
- oInstruction  out  DATA_WIDTH  fetched instruction, registered.
- oInstrValid  out  1  oInstruction updated this cycle.
- oMode  out  2  0 = IDLE, 1 = LOAD, 2 = RUN.
- oWordCount  out  ADDR_WIDTH  number of complete words loaded.
- oLoadError  out  1  sticky load error.

Behaviour:
- Reset, applied at a rising edge while Reset = 0:
  - State goes to IDLE.
  - oInstruction = DEFAULT_WORD; oInstrValid = 0; oWordCount = 0; oLoadError = 0.
  - Byte-lane counter and partial-word register are cleared.
  - Memory array contents are not reset.
  - Reset takes precedence over every other input.
- State machine: IDLE --iLoadStart--> LOAD; LOAD --iLoadDone--> RUN; RUN --iLoadStart--> LOAD.
  - iLoadStart while in LOAD restarts the load: pointer, count, lane and error all clear.
  - iLoadDone in IDLE or RUN is ignored.
  - If iLoadStart and iLoadDone are high together, iLoadStart wins.
- oLoadReady = (state == LOAD) && (oWordCount < DEPTH).
- A byte is accepted when iLoadValid && oLoadReady && !iLoadDone && !iLoadStart.
- Byte ordering is little-endian. Lane k fills bits [8k+7:8k].
  - In the last lane only the low DATA_WIDTH-8*(LANES-1) bits are used; the upper bits are ignored.
- On the cycle the last lane is accepted:
  - The word is written to mem[oWordCount].
  - oWordCount increments, visible the next cycle.
  - The lane counter returns to 0.
- Overflow: if iLoadValid = 1 in LOAD while oWordCount == DEPTH, oLoadError is set and the byte is dropped.
- Partial word at iLoadDone (lane != 0): the partial word is discarded, oLoadError is set, and oWordCount is unchanged.
- oLoadError stays set until Reset or the next iLoadStart.
- Fetch is honoured only in RUN. iFetch high at edge N gives oInstruction and oInstrValid = 1 after edge N+1, i.e. one-cycle latency.
  - oInstruction = mem[iAddress] if iAddress < oWordCount, else DEFAULT_WORD.
  - Back-to-back fetches every cycle are supported at full throughput.
  - oInstrValid is 0 in any cycle without an honoured fetch.
  - oInstruction holds its last value when no fetch is honoured.
- iFetch in IDLE or LOAD: no response; oInstrValid = 0 and oInstruction holds.
- Re-entering LOAD zeroes oWordCount, so stale words from a previous program read as DEFAULT_WORD.

Test Plan:
- Reset, then iFetch with iAddress = 0 in IDLE -> oInstrValid stays 0, oInstruction = 28'h00000AA, oMode = 0.
- iLoadStart, then 12 bytes: 78 56 34 F2, 01 00 00 00, FF FF FF FF; then iLoadDone. Fetch addresses 0, 1, 2, 3 back-to-back -> results one cycle later: 28'h2345678, 28'h0000001, 28'hFFFFFFF, 28'h00000AA; oWordCount = 3; oMode = 2.
- With DEPTH = 4, stream 20 bytes with iLoadValid held high -> oLoadReady drops after the 16th byte; the 17th byte sets oLoadError; oWordCount = 4; memory is unchanged.
- Load 6 bytes, then iLoadDone -> oWordCount = 1, oLoadError = 1; fetch at address 1 returns 28'h00000AA.
- Drive Reset = 0 for one cycle after 2 bytes of a word -> oMode = 0, oWordCount = 0. Reload with 78 56 34 F2 -> address 0 reads 28'h2345678, confirming lanes realigned.
- From RUN with 3 words loaded: iLoadStart, load one word, iLoadDone -> oWordCount = 1, oLoadError = 0; fetch at address 1 returns 28'h00000AA despite the old contents.
